// File: rtl/eth_rx_fifo_pkg.sv
// Shared types for the Ethernet RX store-and-forward frame FIFO.
package eth_rx_fifo_pkg;

    localparam int unsigned CntW = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
    } axis_beat_t;

    typedef struct packed {
        axis_beat_t t;
        logic       tvalid;
    } axi_stream_req_t;

    typedef struct packed {
        logic tready;
    } axi_stream_rsp_t;

    // One buffer slot: end-of-frame marker plus payload byte.
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_RECV,
        WR_DISCARD
    } wr_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/eth_rx_frame_fifo_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module eth_rx_frame_fifo_ram
    import eth_rx_fifo_pkg::*;
#(
    parameter  int unsigned DepthBytes = 4096,
    localparam int unsigned AddrW      = $clog2(DepthBytes)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AddrW-1:0]  waddr_i,
    input  fifo_entry_t       wdata_i,
    input  logic              re_i,
    input  logic [AddrW-1:0]  raddr_i,
    output fifo_entry_t       rdata_o
);

    fifo_entry_t mem [DepthBytes];
    fifo_entry_t rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; output holds when no read is issued.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame FIFO: buffers whole frames from the framing
// stage, commits good frames, drops errored/overflowing ones, and replays
// committed frames on a handshaked AXI Stream.
module eth_rx_frame_fifo
    import eth_rx_fifo_pkg::*;
#(
    parameter  int unsigned DepthBytes = 4096,
    localparam int unsigned AddrW      = $clog2(DepthBytes)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  axi_stream_req_t  rx_axis_req_i,
    output axi_stream_rsp_t  rx_axis_rsp_o,
    output axi_stream_req_t  out_axis_req_o,
    input  axi_stream_rsp_t  out_axis_rsp_i,
    output logic [AddrW:0]   frames_avail_o,
    output logic [CntW-1:0]  drop_err_cnt_o,
    output logic [CntW-1:0]  drop_ovf_cnt_o
);

    typedef logic [AddrW:0] ptr_t;
    localparam ptr_t FullLvl = ptr_t'(DepthBytes);

    // Write side state
    wr_state_e       state_q, state_d;
    ptr_t            wr_ptr_q, wr_ptr_d;
    ptr_t            commit_ptr_q, commit_ptr_d;
    logic [CntW-1:0] err_cnt_q, err_cnt_d;
    logic [CntW-1:0] ovf_cnt_q, ovf_cnt_d;
    logic            commit_evt;
    logic            full;

    // Read side state
    ptr_t            rd_ptr_q, rd_ptr_d;
    ptr_t            frames_q, frames_d;
    logic            rd_vld_q, rd_vld_d;
    fifo_entry_t     ob0_q, ob0_d;
    fifo_entry_t     ob1_q, ob1_d;
    logic [1:0]      ob_cnt_q, ob_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            pop;
    logic            pop_last;
    logic [1:0]      occ_after;

    // RAM interface
    logic            ram_we;
    fifo_entry_t     ram_wdata;
    logic            ram_re;
    fifo_entry_t     ram_rdata;

    eth_rx_frame_fifo_ram #(
        .DepthBytes(DepthBytes)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[AddrW-1:0]),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q[AddrW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Write FSM: store beats, commit on good last, rewind on error or overflow.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        err_cnt_d    = err_cnt_q;
        ovf_cnt_d    = ovf_cnt_q;
        commit_evt   = 1'b0;
        ram_we       = 1'b0;
        ram_wdata    = '{last: rx_axis_req_i.t.last, data: rx_axis_req_i.t.data};
        full         = ((wr_ptr_q - rd_ptr_q) == FullLvl);

        case (state_q)
            WR_IDLE, WR_RECV: begin
                if (rx_axis_req_i.tvalid) begin
                    if (!full) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (rx_axis_req_i.t.last) begin
                            state_d = WR_IDLE;
                            if (rx_axis_req_i.t.user) begin
                                wr_ptr_d  = commit_ptr_q;
                                err_cnt_d = sat_inc(err_cnt_q);
                            end else begin
                                commit_ptr_d = wr_ptr_q + 1'b1;
                                commit_evt   = 1'b1;
                            end
                        end else begin
                            state_d = WR_RECV;
                        end
                    end else begin
                        wr_ptr_d = commit_ptr_q;
                        if (rx_axis_req_i.t.last) begin
                            ovf_cnt_d = sat_inc(ovf_cnt_q);
                            state_d   = WR_IDLE;
                        end else begin
                            state_d = WR_DISCARD;
                        end
                    end
                end
            end
            WR_DISCARD: begin
                if (rx_axis_req_i.tvalid && rx_axis_req_i.t.last) begin
                    ovf_cnt_d = sat_inc(ovf_cnt_q);
                    state_d   = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    // Read side: issue RAM reads so that the two output slots plus the
    // in-flight read never exceed two entries; this keeps one beat per cycle.
    always_comb begin
        pop       = out_valid_q && out_axis_rsp_i.tready;
        pop_last  = pop && ob0_q.last;
        occ_after = ob_cnt_q + 2'(rd_vld_q) - 2'(pop);
        ram_re    = (rd_ptr_q != commit_ptr_q) && (occ_after < 2'd2);
        rd_ptr_d  = rd_ptr_q + ptr_t'(ram_re);
        rd_vld_d  = ram_re;

        ob0_d = ob0_q;
        ob1_d = ob1_q;
        if (pop) begin
            ob0_d = ob1_q;
        end
        if (rd_vld_q) begin
            if ((ob_cnt_q - 2'(pop)) == 2'd0) begin
                ob0_d = ram_rdata;
            end else begin
                ob1_d = ram_rdata;
            end
        end
        ob_cnt_d    = occ_after;
        out_valid_d = (occ_after != 2'd0);

        frames_d = frames_q;
        if (commit_evt && !pop_last) begin
            frames_d = frames_q + 1'b1;
        end else if (!commit_evt && pop_last) begin
            frames_d = frames_q - 1'b1;
        end
    end

    // Write side registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= WR_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            err_cnt_q    <= '0;
            ovf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            err_cnt_q    <= err_cnt_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    // Read side registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q    <= '0;
            frames_q    <= '0;
            rd_vld_q    <= 1'b0;
            ob0_q       <= '0;
            ob1_q       <= '0;
            ob_cnt_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            frames_q    <= frames_d;
            rd_vld_q    <= rd_vld_d;
            ob0_q       <= ob0_d;
            ob1_q       <= ob1_d;
            ob_cnt_q    <= ob_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Output mapping: user is never set on replayed frames.
    always_comb begin
        out_axis_req_o          = '0;
        out_axis_req_o.tvalid   = out_valid_q;
        out_axis_req_o.t.data   = ob0_q.data;
        out_axis_req_o.t.last   = ob0_q.last;
        out_axis_req_o.t.user   = 1'b0;
        rx_axis_rsp_o           = '0;
        rx_axis_rsp_o.tready    = 1'b1;
    end

    assign frames_avail_o = frames_q;
    assign drop_err_cnt_o = err_cnt_q;
    assign drop_ovf_cnt_o = ovf_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Scoreboard bench for eth_rx_frame_fifo: a 4096-deep instance (A) and a
// 64-deep instance (B) are exercised concurrently.
module tb_eth_rx_frame_fifo;
    import eth_rx_fifo_pkg::*;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic rst_a_n, rst_b_n;
    axi_stream_req_t a_in, b_in, a_out, b_out;
    axi_stream_rsp_t a_rxr, b_rxr, a_rdy, b_rdy;
    logic [12:0] a_frames;
    logic [6:0]  b_frames;
    logic [15:0] a_err, a_ovf, b_err, b_ovf;

    eth_rx_frame_fifo dut_a (
        .clk_i(clk), .rst_ni(rst_a_n),
        .rx_axis_req_i(a_in), .rx_axis_rsp_o(a_rxr),
        .out_axis_req_o(a_out), .out_axis_rsp_i(a_rdy),
        .frames_avail_o(a_frames), .drop_err_cnt_o(a_err), .drop_ovf_cnt_o(a_ovf)
    );

    eth_rx_frame_fifo #(.DepthBytes(64)) dut_b (
        .clk_i(clk), .rst_ni(rst_b_n),
        .rx_axis_req_i(b_in), .rx_axis_rsp_o(b_rxr),
        .out_axis_req_o(b_out), .out_axis_rsp_i(b_rdy),
        .frames_avail_o(b_frames), .drop_err_cnt_o(b_err), .drop_ovf_cnt_o(b_ovf)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model state: expected {last,data} beats per instance.
    logic [8:0]  a_q[$];
    logic [8:0]  b_q[$];
    int          a_beats_out = 0;
    int          b_beats_out = 0;
    logic [12:0] a_model_wr = '0;   // bytes of committed frames, mod 2*depth
    int          a_err_exp = 0;
    int          b_occ = 0;          // committed bytes not yet read out of B
    int          b_ovf_exp = 0;
    bit          a_rand_rdy = 1'b0;

    // Monitor A: compare handshaked beats, enforce stable data while stalled.
    initial begin
        logic held;
        logic [8:0] held_v;
        logic [8:0] exp;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_a_n) begin
                held = 1'b0;
            end else begin
                if (held) check("a_stall_stable", {a_out.tvalid, a_out.t.last, a_out.t.data}, {1'b1, held_v});
                held = 1'b0;
                if (a_out.tvalid) begin
                    check("a_user_zero", a_out.t.user, 1'b0);
                    if (a_rdy.tready) begin
                        check("a_sb_nonempty", a_q.size() != 0, 1'b1);
                        if (a_q.size() != 0) begin
                            exp = a_q.pop_front();
                            check("a_beat", {a_out.t.last, a_out.t.data}, exp);
                        end
                        a_beats_out++;
                    end else begin
                        held = 1'b1;
                        held_v = {a_out.t.last, a_out.t.data};
                    end
                end
            end
        end
    end

    // Monitor B: same checks for the small instance.
    initial begin
        logic held;
        logic [8:0] held_v;
        logic [8:0] exp;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_b_n) begin
                held = 1'b0;
            end else begin
                if (held) check("b_stall_stable", {b_out.tvalid, b_out.t.last, b_out.t.data}, {1'b1, held_v});
                held = 1'b0;
                if (b_out.tvalid) begin
                    check("b_user_zero", b_out.t.user, 1'b0);
                    if (b_rdy.tready) begin
                        check("b_sb_nonempty", b_q.size() != 0, 1'b1);
                        if (b_q.size() != 0) begin
                            exp = b_q.pop_front();
                            check("b_beat", {b_out.t.last, b_out.t.data}, exp);
                        end
                        b_beats_out++;
                        b_occ--;
                    end else begin
                        held = 1'b1;
                        held_v = {b_out.t.last, b_out.t.data};
                    end
                end
            end
        end
    end

    // ---------------- instance A helpers ----------------
    task automatic a_tick();
        @(posedge clk);
        #1;
        if (a_rand_rdy) a_rdy.tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic a_beat(input logic [7:0] d, input logic last, input logic user);
        a_in.tvalid = 1'b1;
        a_in.t.data = d;
        a_in.t.last = last;
        a_in.t.user = user;
        a_tick();
        a_in.tvalid = 1'b0;
        a_in.t.data = 8'($urandom);
        a_in.t.last = 1'($urandom);
        a_in.t.user = 1'($urandom);
    endtask

    task automatic a_send(input int len, input bit err, input int gap_pct);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            while ($urandom_range(0, 99) < gap_pct) a_tick();
            if (!err) a_q.push_back({i == len - 1, d});
            a_beat(d, i == len - 1, err && (i == len - 1));
        end
        if (err) a_err_exp++;
        else     a_model_wr = a_model_wr + 13'(len);
    endtask

    task automatic a_drain();
        int n;
        n = 0;
        while ((a_q.size() != 0 || a_out.tvalid) && n < 5000) begin
            a_tick();
            n++;
        end
        check("a_drain_in_time", n < 5000, 1'b1);
    endtask

    // ---------------- instance B helpers ----------------
    task automatic b_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_beat(input logic [7:0] d, input logic last, input logic user);
        b_in.tvalid = 1'b1;
        b_in.t.data = d;
        b_in.t.last = last;
        b_in.t.user = user;
        b_tick();
        b_in.tvalid = 1'b0;
        b_in.t.last = 1'($urandom);
    endtask

    // A frame is kept only if the whole frame fits in the unread space.
    task automatic b_send(input int len);
        logic [7:0] d;
        bit keep;
        keep = (b_occ + len) <= 64;
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            if (keep) b_q.push_back({i == len - 1, d});
            b_beat(d, i == len - 1, 1'b0);
        end
        if (keep) b_occ += len;
        else      b_ovf_exp++;
    endtask

    task automatic b_drain();
        int n;
        n = 0;
        while ((b_q.size() != 0 || b_out.tvalid) && n < 2000) begin
            b_tick();
            n++;
        end
        check("b_drain_in_time", n < 2000, 1'b1);
    endtask

    task automatic check_a_reset_values(input string tag);
        check({tag, "_tvalid"}, a_out.tvalid, 1'b0);
        check({tag, "_data"}, a_out.t.data, 8'h00);
        check({tag, "_last"}, a_out.t.last, 1'b0);
        check({tag, "_user"}, a_out.t.user, 1'b0);
        check({tag, "_frames"}, a_frames, 13'd0);
        check({tag, "_err"}, a_err, 16'd0);
        check({tag, "_ovf"}, a_ovf, 16'd0);
        check({tag, "_rx_tready"}, a_rxr.tready, 1'b1);
    endtask

    // ---------------- test sequences ----------------
    task automatic run_a();
        int beats0;
        logic [7:0] d;
        // 64-byte good frame, tready high: latency and frames_avail 1 -> 0
        a_rdy.tready = 1'b1;
        beats0 = a_beats_out;
        a_send(64, 1'b0, 0);
        check("a_frames_after_commit", a_frames, 13'd1);
        check("a_valid_commit_plus0", a_out.tvalid, 1'b0);
        a_tick();
        check("a_valid_commit_plus1", a_out.tvalid, 1'b0);
        a_tick();
        check("a_valid_commit_plus2", a_out.tvalid, 1'b1);
        a_drain();
        check("a_64_beats_out", a_beats_out - beats0, 64);
        check("a_frames_drained", a_frames, 13'd0);

        // errored 64-byte frame: nothing out, write pointer rewound
        beats0 = a_beats_out;
        a_send(64, 1'b1, 0);
        repeat (5) a_tick();
        check("a_err_cnt_1", a_err, 16'd1);
        check("a_err_no_output", a_beats_out - beats0, 0);
        check("a_wr_ptr_rewound", dut_a.wr_ptr_q, a_model_wr);

        // commit of one frame on the same edge as the last-beat pop of another
        a_rdy.tready = 1'b0;
        d = 8'($urandom);
        a_q.push_back({1'b1, d});
        a_beat(d, 1'b1, 1'b0);
        a_model_wr = a_model_wr + 13'd1;
        repeat (3) a_tick();
        check("a_single_ready", {a_out.tvalid, a_frames}, {1'b1, 13'd1});
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            a_q.push_back({i == 3, d});
            if (i == 3) a_rdy.tready = 1'b1;
            a_beat(d, i == 3, 1'b0);
        end
        a_model_wr = a_model_wr + 13'd4;
        check("a_frames_commit_and_pop", a_frames, 13'd1);
        a_drain();
        check("a_frames_after_pair", a_frames, 13'd0);

        // randomized back-to-back 60-byte frames, random tready, pointer wrap
        a_rand_rdy = 1'b1;
        for (int f = 0; f < 120; f++) begin
            a_send(60, $urandom_range(0, 4) == 0, 10);
            repeat ($urandom_range(0, 2)) a_tick();
        end
        a_drain();
        a_rand_rdy = 1'b0;
        a_rdy.tready = 1'b1;
        check("a_rand_err_cnt", a_err, 16'(a_err_exp));
        check("a_rand_ovf_cnt", a_ovf, 16'd0);
        check("a_rand_frames", a_frames, 13'd0);
        check("a_rand_wr_ptr", dut_a.wr_ptr_q, a_model_wr);

        // reset mid-frame with two committed frames waiting
        a_rdy.tready = 1'b0;
        a_send(20, 1'b0, 0);
        a_send(20, 1'b0, 0);
        for (int i = 0; i < 10; i++) a_beat(8'($urandom), 1'b0, 1'b0);
        check("a_pre_reset_frames", a_frames, 13'd2);
        #2;
        rst_a_n = 1'b0;
        #1;
        check_a_reset_values("a_midreset");
        a_q.delete();
        a_model_wr = '0;
        a_err_exp = 0;
        a_tick();
        a_tick();
        rst_a_n = 1'b1;
        a_rdy.tready = 1'b1;
        beats0 = a_beats_out;
        a_send(30, 1'b0, 0);
        a_drain();
        check("a_post_reset_beats", a_beats_out - beats0, 30);
        check("a_post_reset_frames", a_frames, 13'd0);
        check("a_post_reset_wr_ptr", dut_a.wr_ptr_q, a_model_wr);
    endtask

    task automatic run_b();
        int beats0;
        // 40 + 40 bytes into a 64-deep buffer with the consumer stalled
        b_rdy.tready = 1'b0;
        b_send(40);
        b_send(40);
        check("b_ovf_cnt", b_ovf, 16'(b_ovf_exp));
        check("b_frames_one", b_frames, 7'd1);
        b_rdy.tready = 1'b1;
        b_drain();
        check("b_40_beats_out", b_beats_out, 40);
        check("b_frames_drained", b_frames, 7'd0);

        // 65537 single-beat errored frames: counter must stick at all-ones
        for (int i = 0; i < 65537; i++) b_beat(8'($urandom), 1'b1, 1'b1);
        check("b_err_saturated", b_err, 16'hFFFF);
        check("b_ovf_unchanged", b_ovf, 16'd1);
        beats0 = b_beats_out;
        b_send(10);
        b_drain();
        check("b_after_sat_beats", b_beats_out - beats0, 10);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        a_in = '0;
        b_in = '0;
        a_rdy.tready = 1'b1;
        b_rdy.tready = 1'b0;
        #10;
        check_a_reset_values("a_reset");
        check("b_reset_tvalid", b_out.tvalid, 1'b0);
        check("b_reset_frames", b_frames, 7'd0);
        check("b_reset_counters", {b_err, b_ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        fork
            run_a();
            run_b();
        join
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
